// File: rtl/stream_pkg.sv
// Shared helpers for the stream merge/split blocks.
package stream_pkg;

  // Index width that never collapses to zero bits (N=1 still gets a 1-bit select).
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester after the last winner, wrapping.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant_onehot,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] last;
  logic             found;
  int               j;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    j            = 0;
    for (int i = 1; i <= N; i++) begin
      j = int'(last) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found           = 1'b1;
        grant_onehot[j] = 1'b1;
        grant_idx       = SEL_W'(j);
      end
    end
  end

  // Resetting to N-1 gives source 0 first priority.
  always_ff @(posedge clk) begin
    if (rst)          last <= SEL_W'(N - 1);
    else if (advance) last <= grant_idx;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 registered stream mux with round-robin arbitration; tags each word with its source index.
module stream_mux_rr
  import stream_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic             load;
  logic             any_req;
  logic [N-1:0]     grant_onehot;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;

  assign load    = !out_valid || out_ready;
  assign any_req = |in_valid;

  rr_arbiter #(.N(N)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (in_valid),
    .advance      (load && any_req),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign in_ready = (rst || !load) ? '0 : grant_onehot;

  // AND-OR select off the one-hot grant; avoids a variable part-select.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++)
      if (grant_onehot[k]) sel_data = sel_data | in_data[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized + directed bench for stream_mux_rr against a cycle-level reference model.
module tb_stream_mux_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  stream_mux_rr #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: what the output register should hold, and the last winner.
  bit         m_v;
  logic [7:0] m_d;
  int         m_s;
  int         m_last;

  function automatic int pick(input logic [N-1:0] v);
    for (int i = 1; i <= N; i++)
      if (v[(m_last + i) % N]) return (m_last + i) % N;
    return -1;
  endfunction

  // One clock: drive at negedge, check present state + combinational ready, advance model.
  // g_out is the source the model says transfers this cycle (-1 if none).
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic ordy, output int g_out);
    int g;
    logic ld;
    logic [N-1:0] er;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    ld = !m_v || ordy;
    g  = pick(v);
    er = '0;
    if (!r && ld && g >= 0) er[g] = 1'b1;
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("out_data",  32'(out_data),  32'(m_d));
    chk("out_sel",   32'(out_sel),   32'(m_s));
    chk("in_ready",  32'(in_ready),  32'(er));
    g_out = -1;
    if (r) begin
      m_v = 0; m_d = '0; m_s = 0; m_last = N - 1;
    end else if (ld) begin
      if (g >= 0) begin
        m_v = 1; m_d = d[g*W +: W]; m_s = g; m_last = g; g_out = g;
      end else begin
        m_v = 0;
      end
    end
  endtask

  logic [N*W-1:0] d_all;
  logic [N*W-1:0] d2;
  logic [7:0]     seq2 [3];
  int             exp_sel3 [5];
  int             g;
  logic [N-1:0]   pend_v;
  logic [7:0]     pend_d [N];
  logic [N*W-1:0] rd;

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    m_v = 0; m_d = '0; m_s = 0; m_last = N - 1;
    d_all = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    seq2[0] = 8'h11; seq2[1] = 8'h22; seq2[2] = 8'h33;
    exp_sel3[0] = 0; exp_sel3[1] = 1; exp_sel3[2] = 2; exp_sel3[3] = 3; exp_sel3[4] = 0;

    // Reset then idle
    cycle(1, '0, '0, 1, g);
    cycle(1, '0, '0, 1, g);
    cycle(0, '0, '0, 1, g);
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_ready", 32'(in_ready), 0);

    // Single source, no backpressure
    for (int i = 0; i < 3; i++) begin
      d2 = '0; d2[2*W +: W] = seq2[i];
      cycle(0, 4'b0100, d2, 1, g);
      chk("single_ready", 32'(in_ready), 32'h4);
      if (i > 0) begin
        chk("single_data", 32'(out_data), 32'(seq2[i-1]));
        chk("single_sel",  32'(out_sel), 2);
      end
    end
    cycle(0, '0, '0, 1, g);
    chk("single_data_last", 32'(out_data), 32'h33);

    // All valid after reset: 0,1,2,3,0
    cycle(1, '0, '0, 1, g);
    cycle(0, 4'b1111, d_all, 1, g);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 4'b1111, d_all, 1, g);
      chk("rr_sel",  32'(out_sel), 32'(exp_sel3[i]));
      chk("rr_data", 32'(out_data), 32'(8'hA0 + exp_sel3[i]));
    end

    // Backpressure with source 1's word pending
    cycle(1, '0, '0, 1, g);
    cycle(0, 4'b1111, d_all, 1, g);
    cycle(0, 4'b1111, d_all, 1, g);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 4'b1111, d_all, 0, g);
      chk("bp_sel",   32'(out_sel), 1);
      chk("bp_data",  32'(out_data), 32'hA1);
      chk("bp_ready", 32'(in_ready), 0);
    end
    cycle(0, 4'b1111, d_all, 1, g);
    chk("bp_release_ready", 32'(in_ready), 32'h4);

    // Wrap and skip: last=2, only sources 0,1 valid
    cycle(0, 4'b0011, d_all, 1, g);
    chk("wrap_g0", 32'(in_ready), 32'h1);
    cycle(0, 4'b0011, d_all, 1, g);
    chk("wrap_g1", 32'(in_ready), 32'h2);
    cycle(0, 4'b0011, d_all, 1, g);
    chk("wrap_g2", 32'(in_ready), 32'h1);

    // Reset mid-stream while stalled
    cycle(0, 4'b0011, d_all, 0, g);
    chk("mid_valid_pre", 32'(out_valid), 1);
    cycle(1, 4'b1111, d_all, 0, g);
    cycle(0, 4'b1111, d_all, 1, g);
    chk("mid_valid_post", 32'(out_valid), 0);
    chk("mid_first_grant", 32'(in_ready), 32'h1);

    // Random traffic; sources hold their word until it transfers
    pend_v = '0;
    for (int k = 0; k < N; k++) pend_d[k] = '0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++)
        if (!pend_v[k] && $urandom_range(0, 99) < 40) begin
          pend_v[k] = 1'b1;
          pend_d[k] = 8'($urandom);
        end
      rd = '0;
      for (int k = 0; k < N; k++) rd[k*W +: W] = pend_d[k];
      if ($urandom_range(0, 49) == 0) begin
        cycle(1, pend_v, rd, 1'($urandom), g);
      end else begin
        cycle(0, pend_v, rd, ($urandom_range(0, 99) < 70), g);
        if (g >= 0) pend_v[g] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
N-input to 1-output registered stream multiplexer with round-robin arbitration. It is the merge-side counterpart of the 1:N stream demux: several valid/ready sources share one sink. It emits each accepted word together with its source index, so a downstream demux can route it back. There is one output register stage, and sustained throughput is one word per cycle.

Parameters:
N, 4, number of input streams (>=1)
WIDTH, 8, data width per stream in bits
SEL_W, $clog2(N) with a minimum of 1, width of the source-index field (derived; not overridden)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
in_valid  in  N  per-source valid; bit k belongs to source k
in_data  in  N*WIDTH  flattened source data; source k occupies bits [k*WIDTH +: WIDTH]
in_ready  out  N  per-source ready; at most one bit is high in any cycle
out_valid  out  1  output word valid
out_data  out  WIDTH  output word
out_sel  out  SEL_W  index of the source that produced out_data
out_ready  in  1  sink ready

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Internal last-grant pointer = N-1, so source 0 has first priority after reset.
  - Reset mid-transfer drops any word held in the output register.
  - in_ready is forced to 0 while rst=1.
- Load condition: load = !out_valid || out_ready. The output register accepts a new word only when it is empty or is being drained in the same cycle.
- Arbitration is combinational:
  - Search in_valid starting at index (last+1) mod N, wrapping, and pick the first set bit as grant index g.
  - There is no grant when in_valid is all zero.
- Handshake:
  - in_ready[k] = load && grant && (k==g).
  - in_ready may depend combinationally on in_valid and out_ready.
  - A source transfer occurs when in_valid[k] && in_ready[k].
- On a source transfer from g:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1, last <= g.
  - The word is visible on the output 1 cycle after acceptance.
- If load && no grant: out_valid <= 0. out_data and out_sel hold their values (don't-care).
- Stall: while out_valid && !out_ready, out_valid, out_data and out_sel hold stable, all in_ready=0, and last is unchanged.
- Fairness:
  - Once granted, a source has lowest priority in the next arbitration.
  - With all N sources continuously valid and out_ready=1, the grant order is 0,1,…,N-1,0,… and each source gets one word per N cycles.
- A single active source with out_ready=1 gets one transfer every cycle. The pointer moving to itself does not block it.
- Sources must hold in_data/in_valid stable until their transfer. The block does not check this.
- N=1: degenerates to a one-stage registered pipe with out_sel=0.
- There is no combinational path from in_data to out_data.

Decomposition:
- Shared package stream_pkg: function clog2_min1(n) for SEL_W; no typedefs needed beyond it.
- One sub-module, rr_arbiter (params N):
  - Inputs: clk, rst, req[N], advance (=load && |req).
  - Outputs: grant_onehot[N], grant_idx[SEL_W].
  - Owns the last pointer and its reset value N-1.
- The top level holds the output register, the data select and the ready generation.

Test Plan (N=4, WIDTH=8):
1. Reset then idle → out_valid=0, out_data=0x00, out_sel=0, in_ready=4'b0000 with in_valid=0.
2. Single source, no backpressure: in_valid=4'b0100, in_data[2] = 0x11, 0x22, 0x33 on consecutive cycles, out_ready=1 → in_ready=4'b0100 each cycle; out_data 0x11, 0x22, 0x33 appear one cycle later, each with out_sel=2.
3. All sources valid after reset, out_ready=1, data = 0xA0+k → out_sel sequence 0,1,2,3,0 and out_data 0xA0,0xA1,0xA2,0xA3,0xA0, one per cycle.
4. Backpressure: an output word is pending (out_sel=1, out_data=0xA1), then out_ready=0 for 3 cycles → outputs hold 0xA1/1, in_ready=0000 throughout. When out_ready=1 returns, the next word is from source 2 in the same cycle the held word drains.
5. Wrap and skip: last=2, in_valid=4'b0011 → grant source 0, then source 1, then source 0 again. Source 3 is never granted.
6. Reset mid-stream: rst=1 for one cycle while out_valid=1 and out_ready=0 → next cycle out_valid=0. The first grant after reset goes to the lowest valid index (source 0 if valid).
